// File: rtl/conv_mac_pkg.sv
// Shared types and defaults for the conv_mac_array MAC block.
// Optional saturation is selected by the CONV_MAC_SAT_EN macro (see conv_mac_lane).
package conv_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic MODE_BCAST = 1'b0;
  localparam logic MODE_ELEM  = 1'b1;

  localparam int DEF_LANES = 16;
  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 32;
  localparam int DEF_LW    = 10;

endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: registered product stage followed by the accumulator.
// CONV_MAC_SAT_EN defined: saturating accumulate with sticky flag; otherwise wraps mod 2^AW.
module conv_mac_lane #(
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 beat,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc,
  output logic                 sat
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] prod_q, prod_d;
  logic                 prod_vld_q, prod_vld_d;
  logic signed [AW-1:0] acc_q, acc_d;

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  logic signed [AW:0] sum;
  logic               sat_q, sat_d;
`else
  logic signed [AW-1:0] sum;
`endif

  always_comb begin
    prod_d     = beat ? PW'(a) * PW'(b) : prod_q;
    prod_vld_d = beat;
    acc_d      = acc_q;
`ifdef CONV_MAC_SAT_EN
    sat_d = sat_q;
    // One guard bit: overflow shows up as the top two bits disagreeing.
    sum = (AW+1)'(acc_q) + (AW+1)'(prod_q);
    if (prod_vld_q) begin
      if (sum[AW] != sum[AW-1]) begin
        acc_d = sum[AW] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[AW-1:0];
      end
    end
`else
    sum = acc_q + AW'(prod_q);
    if (prod_vld_q) acc_d = sum;
`endif
    if (clr) begin
      prod_d     = '0;
      prod_vld_d = 1'b0;
      acc_d      = '0;
`ifdef CONV_MAC_SAT_EN
      sat_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
  end

`ifdef CONV_MAC_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign acc = acc_q;

endmodule

// File: rtl/conv_mac_array.sv
// LANES-wide multiply-accumulate array with job FSM (IDLE/ACC/DRAIN/HOLD).
// Handshakes: a beat moves when in_valid && in_ready; results move when out_valid && out_ready. CONV_MAC_SAT_EN enables saturation.
module conv_mac_array
  import conv_mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int LW    = DEF_LW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_mode,
  input  logic [LW-1:0]         cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   image_in,
  input  logic [LANES*DW-1:0]   weight_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*AW-1:0]   result_out,
  output logic                  busy,
  output logic [LANES-1:0]      sat_flag
);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          start_ok, beat, clr;

  // abort overrides every other request in the same cycle.
  assign start_ok = start && !abort && (state_q == IDLE);
  assign beat     = in_valid && in_ready_q && !abort;
  assign clr      = abort || start_ok;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mode_d  = cfg_mode;
          len_d   = cfg_len;
          cnt_d   = '0;
          state_d = (cfg_len == '0) ? DRAIN : ACC;
        end
        ACC: if (beat) begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == len_q - LW'(1)) state_d = DRAIN;
        end
        DRAIN: state_d = HOLD;
        HOLD:  if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0] a_sel;
    assign a_sel = (mode_q == MODE_ELEM) ? image_in[i*DW +: DW] : image_in[DW-1:0];
    conv_mac_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .beat (beat),
      .a    (a_sel),
      .b    (weight_in[i*DW +: DW]),
      .acc  (result_out[i*AW +: AW]),
      .sat  (sat_flag[i])
    );
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array (AW=17 so saturation/wrap corners are reachable).
// Expected sums come from a per-beat arithmetic model; CONV_MAC_SAT_EN selects clamp vs wrap.
`timescale 1ns/1ps
module tb_conv_mac_array;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int LW    = 10;
`ifdef CONV_MAC_SAT_EN
  localparam longint SAT_MAX = (longint'(1) << (AW-1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) << (AW-1));
`endif

  logic                clk = 1'b0;
  logic                rst, start, abort, cfg_mode, in_valid, out_ready;
  logic [LW-1:0]       cfg_len;
  logic                in_ready, out_valid, busy;
  logic [LANES*DW-1:0] image_in, weight_in;
  logic [LANES*AW-1:0] result_out;
  logic [LANES-1:0]    sat_flag;

  int vectors = 0;
  int miscompares = 0;

  logic [LANES*DW-1:0] img_q[$];
  logic [LANES*DW-1:0] wgt_q[$];
  logic [AW-1:0]       exp_q[$];
  logic [LANES-1:0]    exp_sat;

  always #5 clk = ~clk;

  conv_mac_array #(.LANES(LANES), .DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
    .image_in(image_in), .weight_in(weight_in), .out_valid(out_valid),
    .out_ready(out_ready), .result_out(result_out), .busy(busy), .sat_flag(sat_flag)
  );

  function automatic logic [LANES*DW-1:0] rand_vec();
    logic [LANES*DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic fill_random(input int len);
    img_q.delete();
    wgt_q.delete();
    for (int k = 0; k < len; k++) begin
      img_q.push_back(rand_vec());
      wgt_q.push_back(rand_vec());
    end
  endtask

  // Reference: each lane sums a*b beat by beat (clamped per step when saturating).
  task automatic build_expected(input bit mode, input int len);
    logic [LANES*DW-1:0] iv, wv;
    logic signed [DW-1:0] a, b;
    longint acc;
    logic [63:0] bits;
    exp_q.delete();
    exp_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      acc = 0;
      for (int k = 0; k < len; k++) begin
        iv = img_q[k];
        wv = wgt_q[k];
        a = mode ? iv[i*DW +: DW] : iv[DW-1:0];
        b = wv[i*DW +: DW];
        acc = acc + longint'(a) * longint'(b);
`ifdef CONV_MAC_SAT_EN
        if (acc > SAT_MAX) begin acc = SAT_MAX; exp_sat[i] = 1'b1; end
        if (acc < SAT_MIN) begin acc = SAT_MIN; exp_sat[i] = 1'b1; end
`endif
      end
      bits = acc;
      exp_q.push_back(bits[AW-1:0]);
    end
  endtask

  // Starts a job at a negedge in IDLE and feeds img_q/wgt_q; returns one negedge after the last beat.
  task automatic drive_job(input bit mode, input int len, input int gap);
    cfg_mode = mode;
    cfg_len  = LW'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      in_valid  = 1'b1;
      image_in  = img_q[k];
      weight_in = wgt_q[k];
      @(negedge clk);
      in_valid  = 1'b0;
      image_in  = rand_vec();
      weight_in = rand_vec();
      if (k < len - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
    in_valid = 1'b0; out_ready = 1'b0; image_in = '0; weight_in = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    vectors++; if (result_out !== '0) begin miscompares++; $display("FAIL reset_result got %h expected 0", result_out); end
    vectors++; if (sat_flag !== '0) begin miscompares++; $display("FAIL reset_sat got %h expected 0", sat_flag); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b expected 0", busy); end
  endtask

  task automatic test_elementwise();
    logic [LANES*DW-1:0] iv, wv;
    logic [AW-1:0] got, want;
    for (int i = 0; i < LANES; i++) begin
      iv[i*DW +: DW] = DW'(i - 8);
      wv[i*DW +: DW] = DW'(2);
    end
    img_q.delete(); wgt_q.delete();
    repeat (3) begin img_q.push_back(iv); wgt_q.push_back(wv); end
    drive_job(1'b1, 3, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL elem_early_valid got %b expected 0", out_valid); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL elem_latency got %b expected 1", out_valid); end
    for (int i = 0; i < LANES; i++) begin
      got  = result_out[i*AW +: AW];
      want = AW'(6 * (i - 8));
      vectors++;
      if (got !== want) begin miscompares++; $display("FAIL elem_lane%0d got %0d expected %0d", i, $signed(got), $signed(want)); end
    end
    finish_job();
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL elem_release got busy=%b valid=%b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_broadcast();
    logic [LANES*DW-1:0] iv, wv;
    logic [AW-1:0] got, want;
    iv = rand_vec();
    iv[DW-1:0] = DW'(-3);
    for (int i = 0; i < LANES; i++) wv[i*DW +: DW] = DW'(i);
    img_q.delete(); wgt_q.delete();
    img_q.push_back(iv); wgt_q.push_back(wv);
    drive_job(1'b0, 1, 0);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bcast_latency got %b expected 1", out_valid); end
    for (int i = 0; i < LANES; i++) begin
      got  = result_out[i*AW +: AW];
      want = AW'(-3 * i);
      vectors++;
      if (got !== want) begin miscompares++; $display("FAIL bcast_lane%0d got %0d expected %0d", i, $signed(got), $signed(want)); end
    end
    finish_job();
  endtask

  task automatic test_gaps_stall();
    bit mode;
    logic [AW-1:0] got;
    mode = 1'($urandom_range(0, 1));
    fill_random(4);
    build_expected(mode, 4);
    drive_job(mode, 4, 2);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_early_valid got %b expected 0", out_valid); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL gap_hold_valid cyc%0d got %b expected 1", c, out_valid); end
      for (int i = 0; i < LANES; i++) begin
        got = result_out[i*AW +: AW];
        vectors++;
        if (got !== exp_q[i]) begin miscompares++; $display("FAIL gap_lane%0d cyc%0d got %0d expected %0d", i, c, $signed(got), $signed(exp_q[i])); end
      end
      @(negedge clk);
    end
    finish_job();
    for (int c = 0; c < 3; c++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_single_handshake cyc%0d got %b expected 0", c, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    logic [LANES*DW-1:0] v;
    logic [AW-1:0] got, want;
    logic [LANES-1:0] want_sat;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 8'h80;
    img_q.delete(); wgt_q.delete();
    repeat (8) begin img_q.push_back(v); wgt_q.push_back(v); end
`ifdef CONV_MAC_SAT_EN
    want = AW'(65535);
    want_sat = '1;
`else
    want = '0;
    want_sat = '0;
`endif
    drive_job(1'b1, 8, 0);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sat_latency got %b expected 1", out_valid); end
    for (int i = 0; i < LANES; i++) begin
      got = result_out[i*AW +: AW];
      vectors++;
      if (got !== want) begin miscompares++; $display("FAIL sat_lane%0d got %0d expected %0d", i, got, want); end
    end
    vectors++; if (sat_flag !== want_sat) begin miscompares++; $display("FAIL sat_flag got %h expected %h", sat_flag, want_sat); end
    finish_job();
  endtask

  task automatic test_abort();
    logic [AW-1:0] got;
    // abort together with start in IDLE: start must lose.
    abort = 1'b1; start = 1'b1; cfg_len = LW'(3);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle_start got busy=%b expected 0", busy); end
    // abort mid-ACC together with start and a beat.
    fill_random(3);
    cfg_mode = 1'b1; cfg_len = LW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; image_in = img_q[k]; weight_in = wgt_q[k];
      @(negedge clk);
    end
    abort = 1'b1; start = 1'b1; image_in = img_q[2]; weight_in = wgt_q[2];
    @(negedge clk);
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_acc got busy=%b rdy=%b valid=%b expected 0 0 0", busy, in_ready, out_valid); end
    vectors++; if (result_out !== '0) begin miscompares++; $display("FAIL abort_acc_result got %h expected 0", result_out); end
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle got %b expected 0", out_valid); end
    // fresh job must start from zero accumulators.
    fill_random(2);
    build_expected(1'b1, 2);
    drive_job(1'b1, 2, 0);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL abort_fresh_latency got %b expected 1", out_valid); end
    for (int i = 0; i < LANES; i++) begin
      got = result_out[i*AW +: AW];
      vectors++;
      if (got !== exp_q[i]) begin miscompares++; $display("FAIL abort_fresh_lane%0d got %0d expected %0d", i, $signed(got), $signed(exp_q[i])); end
    end
    // abort in HOLD beats out_ready and drops out_valid.
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || result_out !== '0) begin
      miscompares++; $display("FAIL abort_hold got valid=%b result=%h expected 0 0", out_valid, result_out); end
  endtask

  task automatic test_reset_midjob();
    logic [LANES*DW-1:0] v;
    logic [AW-1:0] got;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 8'h01;
    cfg_mode = 1'b1; cfg_len = LW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; image_in = v; weight_in = v;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_async_ctrl got busy=%b rdy=%b expected 0 0", busy, in_ready); end
    vectors++; if (result_out !== '0) begin miscompares++; $display("FAIL rst_async_result got %h expected 0", result_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random(3);
    build_expected(1'b0, 3);
    drive_job(1'b0, 3, 1);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_latency got %b expected 1", out_valid); end
    for (int i = 0; i < LANES; i++) begin
      got = result_out[i*AW +: AW];
      vectors++;
      if (got !== exp_q[i]) begin miscompares++; $display("FAIL rst_fresh_lane%0d got %0d expected %0d", i, $signed(got), $signed(exp_q[i])); end
    end
    finish_job();
  endtask

  task automatic test_zero_len();
    drive_job(1'b1, 0, 0);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_drain got valid=%b rdy=%b expected 0 0", out_valid, in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL zero_latency got %b expected 1", out_valid); end
    vectors++; if (result_out !== '0) begin miscompares++; $display("FAIL zero_result got %h expected 0", result_out); end
    start = 1'b1; cfg_len = LW'(5);
    @(negedge clk);
    start = 1'b0;
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_start_in_hold got valid=%b rdy=%b expected 1 0", out_valid, in_ready); end
    finish_job();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_release got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit mode;
    int len, gap;
    logic [AW-1:0] got;
    for (int j = 0; j < 8; j++) begin
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 6);
      gap  = $urandom_range(0, 2);
      fill_random(len);
      build_expected(mode, len);
      drive_job(mode, len, gap);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_early_valid got %b expected 0", j, out_valid); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_latency got %b expected 1", j, out_valid); end
      for (int i = 0; i < LANES; i++) begin
        got = result_out[i*AW +: AW];
        vectors++;
        if (got !== exp_q[i]) begin miscompares++; $display("FAIL rnd%0d_lane%0d got %0d expected %0d", j, i, $signed(got), $signed(exp_q[i])); end
      end
      vectors++; if (sat_flag !== exp_sat) begin miscompares++; $display("FAIL rnd%0d_sat got %h expected %h", j, sat_flag, exp_sat); end
      finish_job();
    end
  endtask

  initial begin
    test_reset();
    test_elementwise();
    test_broadcast();
    test_gaps_stall();
    test_saturation();
    test_abort();
    test_reset_midjob();
    test_zero_len();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_mac_array.md
CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

Interface
REQ-001 Parameter LANES, default 16: number of parallel MAC lanes.
REQ-002 Parameter DW, default 8: signed operand width per lane.
REQ-003 Parameter AW, default 32: signed accumulator and result width per lane; AW SHALL be at least 2*DW+1.
REQ-004 Parameter LW, default 10: width of the beat-count field.
REQ-005 Clock and reset SHALL be exactly: one clock clk; reset rst, asynchronous, active-high.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a job; accepted only in IDLE
- abort  in  1  cancel the current job
- cfg_mode  in  1  0 = broadcast (image lane 0 to all lanes), 1 = elementwise; sampled on start
- cfg_len  in  LW  beats to accumulate; sampled on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  array accepts a beat
- image_in  in  LANES*DW  signed operands, lane i at [i*DW +: DW]
- weight_in  in  LANES*DW  signed operands, lane i at [i*DW +: DW]
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- result_out  out  LANES*AW  signed lane results, lane i at [i*AW +: AW]
- busy  out  1  state is not IDLE
- sat_flag  out  LANES  per-lane saturation sticky (zero when CONV_MAC_SAT_EN is undefined)

Function
REQ-007 The FSM SHALL have states IDLE, ACC, DRAIN and HOLD.
REQ-008 On start in IDLE, the block SHALL latch cfg_mode and cfg_len, clear all accumulators and sat_flag, and go to ACC; if cfg_len==0 it SHALL go to DRAIN instead.
REQ-009 start SHALL be ignored outside IDLE.
REQ-010 in_ready SHALL be 1 only in ACC; a beat is accepted when in_valid && in_ready.
REQ-011 Each accepted beat SHALL register per-lane product a_i*b_i (2*DW signed) in a product stage, where a_i = lane-0 image in broadcast mode and image lane i in elementwise mode.
REQ-012 The accumulator SHALL add the sign-extended product one cycle after the beat is accepted.
REQ-013 After the cfg_len-th accepted beat, the FSM SHALL go ACC->DRAIN; DRAIN lasts exactly one cycle, so the final product is added; then DRAIN->HOLD.
REQ-014 In HOLD, out_valid SHALL be 1 and result_out SHALL equal the accumulators, held stable until out_ready.
REQ-015 On out_valid && out_ready the FSM SHALL go to IDLE; the result is consumed the same cycle.
REQ-016 Latency: out_valid SHALL rise 2 cycles after the cycle the final beat is accepted.
REQ-017 When abort is high in any state, the FSM SHALL go to IDLE next cycle, clear accumulators and the product stage, and drop out_valid; abort SHALL win over start, beat and out_ready in the same cycle.
REQ-018 An in_valid gap in ACC SHALL stall counting with no accumulation; the beat counter SHALL never wrap within a job.

Reset
REQ-019 While rst is high: state = IDLE; accumulators, product registers, beat counter, latched config, result_out, sat_flag = 0; in_ready, out_valid, busy = 0.
REQ-020 rst SHALL take effect asynchronously mid-job, discarding partial results.

Configuration
REQ-021 CONV_MAC_SAT_EN defined: per-lane accumulation SHALL saturate to the AW-bit signed max/min and set sticky sat_flag[i].
REQ-022 CONV_MAC_SAT_EN undefined: accumulation SHALL wrap modulo 2^AW, and sat_flag SHALL be tied to 0.

Structure
REQ-023 Package conv_mac_pkg SHALL hold the FSM state enum, mode encodings (MODE_BCAST=0, MODE_ELEM=1) and default parameter constants.
REQ-024 Sub-module conv_mac_lane (product register, accumulator, saturation logic) SHALL be instantiated LANES times via generate; the FSM SHALL live in conv_mac_array.

Verification
REQ-025 Elementwise, LANES=16, cfg_len=3, lane i image=i-8, weight=2, three back-to-back beats -> result lane i = 6*(i-8), out_valid 2 cycles after the third beat.
REQ-026 Broadcast, image lane 0=-3 (other lanes random), weight lane i=i, cfg_len=1 -> result lane i = -3*i.
REQ-027 cfg_len=4 with in_valid gaps of 2 cycles between beats, out_ready held low 5 cycles in HOLD -> correct sums, result_out stable, single out_valid handshake.
REQ-028 SAT_EN, DW=8, AW=17, operands -128*-128 for cfg_len=8 -> lane = 65535, sat_flag=1; without the macro -> wrapped value 131072 mod 2^17 = 0.
REQ-029 abort asserted mid-ACC together with start; rst pulsed mid-job -> IDLE, out_valid=0, next job starts from zero accumulators.
REQ-030 cfg_len=0 -> out_valid after DRAIN with all results 0; start during HOLD -> ignored.
